// File: rtl/ascon_pkg.sv
// Shared constants, FSM encoding and word-count helper for the Ascon tag verifier.
package ascon_pkg;

  localparam int TAG_W = 128;

  typedef enum logic [1:0] {
    VERIFY_IDLE    = 2'd0,
    VERIFY_COMPARE = 2'd1,
    VERIFY_RESULT  = 2'd2
  } verify_state_t;

  function automatic int num_words(input int w);
    return TAG_W / w;
  endfunction

endpackage

// File: rtl/ascon_ct_compare.sv
// Constant-time word-serial tag comparator: ORs the XOR of one W-bit word pair per cycle, MSB word first.
// done/mismatch are combinational and describe the word being processed on the current edge.
module ascon_ct_compare
  import ascon_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [TAG_W-1:0] op_a,
  input  logic [TAG_W-1:0] op_b,
  output logic             done,
  output logic             mismatch
);

  localparam int NW = num_words(W);
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  logic [CW-1:0]    word_ctr;
  logic             diff;
  logic [TAG_W-1:0] a_sh;
  logic [TAG_W-1:0] b_sh;
  logic             word_diff;

  // Word i lives at bits [127 - i*W -: W]; shift it down to the bottom.
  always_comb begin
    a_sh      = op_a >> ((NW - 1 - int'(word_ctr)) * W);
    b_sh      = op_b >> ((NW - 1 - int'(word_ctr)) * W);
    word_diff = |(a_sh[W-1:0] ^ b_sh[W-1:0]);
  end

  assign done     = run && (word_ctr == LAST);
  assign mismatch = diff | word_diff;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      diff     <= 1'b0;
      word_ctr <= '0;
    end else if (run) begin
      diff     <= mismatch;
      word_ctr <= word_ctr + CW'(1);
    end
  end

endmodule

// File: rtl/ascon_tag_verify.sv
// Captures plaintext and both tags on decryption done, compares tags in constant time,
// releases plaintext only on match, zeroizes captured data on acknowledge.
module ascon_tag_verify
  import ascon_pkg::*;
#(
  parameter int y = 40,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             decryption_ready,
  input  logic [y-1:0]     plain_text,
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W-1:0] received_tag,
  input  logic             result_ack,
  output logic             verify_done,
  output logic             pt_valid,
  output logic             auth_fail,
  output logic [y-1:0]     pt_out,
  output logic             busy,
  output logic [7:0]       fail_count
);

  verify_state_t    state, state_nxt;
  logic             ready_q;
  logic             capture;
  logic             ack;
  logic             cmp_done;
  logic             cmp_mismatch;
  logic [y-1:0]     pt_cap;
  logic [TAG_W-1:0] tag_cap;
  logic [TAG_W-1:0] rx_cap;

  // Rising edges outside IDLE are dropped, not queued.
  assign capture = decryption_ready && !ready_q && (state == VERIFY_IDLE);
  assign ack     = result_ack && (state == VERIFY_RESULT);

  ascon_ct_compare #(.W(W)) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .start    (capture || ack),
    .run      (state == VERIFY_COMPARE),
    .op_a     (tag_cap),
    .op_b     (rx_cap),
    .done     (cmp_done),
    .mismatch (cmp_mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= VERIFY_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      VERIFY_IDLE:    if (capture)  state_nxt = VERIFY_COMPARE;
      VERIFY_COMPARE: if (cmp_done) state_nxt = VERIFY_RESULT;
      VERIFY_RESULT:  if (ack)      state_nxt = VERIFY_IDLE;
      default:                      state_nxt = VERIFY_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      pt_cap      <= '0;
      tag_cap     <= '0;
      rx_cap      <= '0;
      verify_done <= 1'b0;
      pt_valid    <= 1'b0;
      auth_fail   <= 1'b0;
      pt_out      <= '0;
      busy        <= 1'b0;
      fail_count  <= 8'd0;
    end else begin
      ready_q <= decryption_ready;
      if (capture) begin
        pt_cap  <= plain_text;
        tag_cap <= tag;
        rx_cap  <= received_tag;
        busy    <= 1'b1;
      end
      if (cmp_done) begin
        verify_done <= 1'b1;
        pt_valid    <= !cmp_mismatch;
        auth_fail   <= cmp_mismatch;
        pt_out      <= cmp_mismatch ? '0 : pt_cap;
        if (cmp_mismatch && (fail_count != 8'hFF)) fail_count <= fail_count + 8'd1;
      end
      if (ack) begin
        pt_cap      <= '0;
        tag_cap     <= '0;
        rx_cap      <= '0;
        verify_done <= 1'b0;
        pt_valid    <= 1'b0;
        auth_fail   <= 1'b0;
        pt_out      <= '0;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_tag_verify.sv
// Self-checking bench: vector table, random ops against a tag-equality model, and multi-cycle corner cases.
module tb_ascon_tag_verify;
  import ascon_pkg::*;

  localparam logic [127:0] K = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [39:0]  P = 40'hA5_A55A_5AC3;

  logic         clk = 1'b0;
  logic         rst;
  logic         dr, ack;
  logic [39:0]  pt_in;
  logic [127:0] tag_in, rx_in;
  logic         vd, pv, af, bz;
  logic [39:0]  pto;
  logic [7:0]   fc;

  logic         dr8, ack8;
  logic         vd8, pv8, af8, bz8;
  logic [39:0]  pto8;
  logic [7:0]   fc8;

  int checks = 0;
  int errors = 0;
  int fc_model = 0;

  always #5 clk = ~clk;

  ascon_tag_verify #(.y(40), .W(32)) dut (
    .clk(clk), .rst(rst), .decryption_ready(dr), .plain_text(pt_in), .tag(tag_in),
    .received_tag(rx_in), .result_ack(ack), .verify_done(vd), .pt_valid(pv),
    .auth_fail(af), .pt_out(pto), .busy(bz), .fail_count(fc));

  ascon_tag_verify #(.y(40), .W(8)) dut8 (
    .clk(clk), .rst(rst), .decryption_ready(dr8), .plain_text(pt_in), .tag(tag_in),
    .received_tag(rx_in), .result_ack(ack8), .verify_done(vd8), .pt_valid(pv8),
    .auth_fail(af8), .pt_out(pto8), .busy(bz8), .fail_count(fc8));

  typedef struct {
    logic [39:0]  pt;
    logic [127:0] tg;
    logic [127:0] rx;
    logic         exp_fail;
    logic [39:0]  exp_pt;
    logic [7:0]   exp_fc;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " verify_done"}, 128'(vd), 0);
    chk({nm, " pt_valid"}, 128'(pv), 0);
    chk({nm, " auth_fail"}, 128'(af), 0);
    chk({nm, " pt_out"}, 128'(pto), 0);
    chk({nm, " busy"}, 128'(bz), 0);
    chk({nm, " state"}, 128'(dut.state), 128'(VERIFY_IDLE));
  endtask

  // Raise decryption_ready, wait for the result, compare against the expected outcome.
  task automatic do_op(input logic [39:0] p, input logic [127:0] t, input logic [127:0] r,
                       input logic exp_fail, input logic [39:0] exp_pt, input logic [7:0] exp_fc,
                       input string nm);
    int cnt;
    pt_in = p; tag_in = t; rx_in = r; dr = 1'b1;
    step();
    chk({nm, " busy_after_capture"}, 128'(bz), 1);
    cnt = 0;
    while (!vd && cnt < 40) begin
      step();
      cnt++;
    end
    chk({nm, " latency"}, 128'(cnt), 4);
    chk({nm, " auth_fail"}, 128'(af), 128'(exp_fail));
    chk({nm, " pt_valid"}, 128'(pv), 128'(!exp_fail));
    chk({nm, " pt_out"}, 128'(pto), 128'(exp_pt));
    chk({nm, " fail_count"}, 128'(fc), 128'(exp_fc));
    chk({nm, " busy"}, 128'(bz), 1);
  endtask

  task automatic do_ack(input logic hold, input string nm);
    if (!hold) dr = 1'b0;
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk_idle({nm, " ack"});
    chk({nm, " zero pt_cap"}, 128'(dut.pt_cap), 0);
    chk({nm, " zero tag_cap"}, dut.tag_cap, 0);
    chk({nm, " zero rx_cap"}, dut.rx_cap, 0);
  endtask

  task automatic model_op(input logic [127:0] t, input logic [127:0] r,
                          output logic exp_fail, output logic [7:0] exp_fc);
    exp_fail = (t != r);
    if (exp_fail && fc_model < 255) fc_model++;
    exp_fc = 8'(fc_model);
  endtask

  initial begin
    vec_t         vecs[5];
    logic         ef;
    logic [7:0]   efc;
    logic [127:0] t, r;
    logic [39:0]  p;
    int           cnt;

    vecs[0] = '{P, K, K, 1'b0, P, 8'd0};
    vecs[1] = '{P, K, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211, 1'b1, 40'd0, 8'd1};
    vecs[2] = '{P, K, 128'h8123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 40'd0, 8'd2};
    vecs[3] = '{P, K, 128'h0123_4567_89AB_CDEE_FEDC_BA98_7654_3210, 1'b1, 40'd0, 8'd3};
    vecs[4] = '{40'hFF_FFFF_FFFF, 128'd0, 128'd0, 1'b0, 40'hFF_FFFF_FFFF, 8'd3};

    rst = 1'b1; dr = 1'b0; ack = 1'b0; dr8 = 1'b0; ack8 = 1'b0;
    pt_in = '0; tag_in = '0; rx_in = '0;
    step(); step();
    chk_idle("reset");
    chk("reset fail_count", 128'(fc), 0);
    rst = 1'b0;
    repeat (7) step();

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].pt, vecs[i].tg, vecs[i].rx, vecs[i].exp_fail, vecs[i].exp_pt,
            vecs[i].exp_fc, $sformatf("vec%0d", i));
      if (vecs[i].exp_fail) fc_model++;
      do_ack(1'b0, $sformatf("vec%0d", i));
      step();
    end

    // Rising edge during RESULT is ignored; ack while ready held high gives no new capture
    do_op(P, K, K, 1'b0, P, 8'(fc_model), "hold");
    dr = 1'b0; step();
    dr = 1'b1; pt_in = 40'h11_2233_4455; step();
    chk("ignored edge state", 128'(dut.state), 128'(VERIFY_RESULT));
    chk("ignored edge pt_out", 128'(pto), 128'(P));
    chk("ignored edge verify_done", 128'(vd), 1);
    do_ack(1'b1, "hold");
    repeat (3) step();
    chk("held ready no capture busy", 128'(bz), 0);
    chk("held ready no capture state", 128'(dut.state), 128'(VERIFY_IDLE));
    dr = 1'b0; step();

    // Ack coincident with a new rising edge: ack wins, edge consumed
    do_op(P, K, K, 1'b0, P, 8'(fc_model), "coinc");
    dr = 1'b0; step();
    dr = 1'b1; ack = 1'b1; step();
    ack = 1'b0;
    chk_idle("coinc ack");
    step(); step();
    chk("coinc no capture", 128'(bz), 0);
    dr = 1'b0; step();

    // Ack in IDLE does nothing
    ack = 1'b1; step(); ack = 1'b0; step();
    chk_idle("idle ack");
    chk("idle ack fail_count", 128'(fc), 128'(fc_model));

    // Reset in the second COMPARE cycle
    pt_in = P; tag_in = K; rx_in = K; dr = 1'b1;
    step(); step();
    chk("pre-reset state", 128'(dut.state), 128'(VERIFY_COMPARE));
    rst = 1'b1; step(); rst = 1'b0; dr = 1'b0;
    chk_idle("midrst");
    chk("midrst fail_count", 128'(fc), 0);
    chk("midrst pt_cap", 128'(dut.pt_cap), 0);
    chk("midrst tag_cap", dut.tag_cap, 0);
    chk("midrst ready_q", 128'(dut.ready_q), 0);
    fc_model = 0;
    step();
    do_op(P, K, K, 1'b0, P, 8'd0, "postrst");
    do_ack(1'b0, "postrst");
    step();

    // Random operations against the equality model
    for (int i = 0; i < 40; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      r = t;
      if ($urandom_range(1, 0) == 1) r[$urandom_range(127, 0)] ^= 1'b1;
      p = 40'({$urandom, $urandom});
      model_op(t, r, ef, efc);
      do_op(p, t, r, ef, ef ? 40'd0 : p, efc, $sformatf("rnd%0d", i));
      do_ack(1'b0, $sformatf("rnd%0d", i));
      step();
    end

    // Saturation of fail_count
    for (int i = 0; i < 300; i++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      r = ~t;
      model_op(t, r, ef, efc);
      do_op(P, t, r, ef, 40'd0, efc, $sformatf("sat%0d", i));
      do_ack(1'b0, $sformatf("sat%0d", i));
      step();
    end
    chk("saturated fail_count", 128'(fc), 255);

    // W=8 instance: 16-cycle latency
    pt_in = P; tag_in = K; rx_in = K; dr8 = 1'b1;
    step();
    cnt = 0;
    while (!vd8 && cnt < 60) begin
      step();
      cnt++;
    end
    chk("w8 latency", 128'(cnt), 16);
    chk("w8 pt_valid", 128'(pv8), 1);
    chk("w8 pt_out", 128'(pto8), 128'(P));
    dr8 = 1'b0; ack8 = 1'b1; step(); ack8 = 1'b0;
    chk("w8 ack verify_done", 128'(vd8), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
